// File: rtl/noc_params.sv
// Shared NoC types and sizing for the router input port.
// Holds flit layout, port and label encodings, and the per-VC state enum.
package noc_params;

  localparam int MESH_SIZE_X      = 4;
  localparam int MESH_SIZE_Y      = 4;
  localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
  localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
  localparam int VC_NUM           = 2;
  localparam int VC_SIZE          = $clog2(VC_NUM);
  localparam int DATA_SIZE        = 16;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

  typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_t;

  typedef struct packed {
    flit_label_t                 flit_label;
    logic [VC_SIZE-1:0]          vc_id;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    logic [DATA_SIZE-1:0]        data;
  } flit_t;

  function automatic logic is_head(input flit_label_t l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  function automatic logic is_tail(input flit_label_t l);
    return (l == TAIL) || (l == HEADTAIL);
  endfunction

endpackage

// File: rtl/rc_unit.sv
// XY dimension-ordered route computation: resolve X first, then Y.
// Smaller y is NORTH, larger y is SOUTH; a match on both is LOCAL.
module rc_unit
  import noc_params::*;
#(
  parameter int X_CURRENT = MESH_SIZE_X / 2,
  parameter int Y_CURRENT = MESH_SIZE_Y / 2
) (
  input  logic [DEST_ADDR_SIZE_X-1:0] i_x_dest,
  input  logic [DEST_ADDR_SIZE_Y-1:0] i_y_dest,
  output port_t                       o_out_port
);

  localparam logic [DEST_ADDR_SIZE_X-1:0] XC = DEST_ADDR_SIZE_X'(X_CURRENT);
  localparam logic [DEST_ADDR_SIZE_Y-1:0] YC = DEST_ADDR_SIZE_Y'(Y_CURRENT);

  // Pick the output direction from the destination offset
  always_comb begin
    o_out_port = LOCAL;
    if (i_x_dest > XC)      o_out_port = EAST;
    else if (i_x_dest < XC) o_out_port = WEST;
    else if (i_y_dest < YC) o_out_port = NORTH;
    else if (i_y_dest > YC) o_out_port = SOUTH;
  end

endmodule

// File: rtl/vc_channel.sv
// One virtual channel: flit FIFO, IDLE/VA/ACTIVE FSM, latched route and
// latched downstream VC. A stray BODY/TAIL at the front of an IDLE VC is
// discarded and flagged; it never produces a credit.
// Handshake: i_sa_grant is already qualified with the VC select by the
// parent; a pop happens only when this VC is ACTIVE and non-empty, so a
// grant to a non-requesting VC has no effect.
module vc_channel
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int X_CURRENT   = MESH_SIZE_X / 2,
  parameter int Y_CURRENT   = MESH_SIZE_Y / 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  flit_t              i_flit,
  input  logic               i_va_grant,
  input  logic [VC_SIZE-1:0] i_va_vc_new,
  input  logic               i_sa_grant,
  output logic               o_va_req,
  output logic               o_sa_req,
  output port_t              o_out_port,
  output logic               o_fwd_pop,
  output flit_t              o_fwd_flit,
  output logic               o_err
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int PW = AW + 1;

  flit_t              r_mem [BUFFER_SIZE];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  vc_state_t          r_state;
  port_t              r_out_port;
  logic [VC_SIZE-1:0] r_vc_new;

  logic  w_empty;
  logic  w_full;
  flit_t w_front;
  port_t w_rc_port;
  logic  w_discard;
  logic  w_fwd;
  logic  w_pop;
  logic  w_wr_en;
  logic  w_drop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_front = r_mem[r_rd_ptr[AW-1:0]];

  assign w_discard = (r_state == IDLE) && !w_empty && !is_head(w_front.flit_label);
  assign w_fwd     = (r_state == ACTIVE) && !w_empty && i_sa_grant;
  assign w_pop     = w_discard || w_fwd;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept
  assign w_wr_en   = i_push && (!w_full || w_pop);
  assign w_drop    = i_push && w_full && !w_pop;

  assign o_va_req   = (r_state == VA);
  assign o_sa_req   = (r_state == ACTIVE) && !w_empty;
  assign o_out_port = r_out_port;
  assign o_fwd_pop  = w_fwd;
  assign o_err      = w_drop || w_discard;

  rc_unit #(
    .X_CURRENT (X_CURRENT),
    .Y_CURRENT (Y_CURRENT)
  ) u_rc (
    .i_x_dest   (w_front.x_dest),
    .i_y_dest   (w_front.y_dest),
    .o_out_port (w_rc_port)
  );

  // Forwarded copy of the front flit carries the downstream VC
  always_comb begin
    o_fwd_flit       = w_front;
    o_fwd_flit.vc_id = r_vc_new;
  end

  // Flit storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_flit;
  end

  // FIFO pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Per-VC packet FSM: route on head, wait for VC grant, forward to tail
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_out_port <= LOCAL;
      r_vc_new   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty && is_head(w_front.flit_label)) begin
            r_out_port <= w_rc_port;
            r_state    <= VA;
          end
        end
        VA: begin
          if (i_va_grant) begin
            r_vc_new <= i_va_vc_new;
            r_state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (w_fwd && is_tail(w_front.flit_label)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vc_input_port.sv
// Router input port with VC_NUM virtual channels. Steers incoming flits to
// their VC FIFO, exposes VA/SA requests, and registers the forwarded flit
// and the upstream credit one cycle after the switch grant.
// Optional macro IP_PERF_CNT_EN adds perf_flits_o: a saturating 16-bit
// forwarded-flit counter per VC.
module vc_input_port
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int X_CURRENT   = MESH_SIZE_X / 2,
  parameter int Y_CURRENT   = MESH_SIZE_Y / 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  flit_t                           data_i,
  input  logic                            valid_flit_i,
  output logic                            credit_valid_o,
  output logic [VC_SIZE-1:0]              credit_vc_o,
  output port_t [VC_NUM-1:0]              out_port_o,
  output logic [VC_NUM-1:0]               va_req_o,
  input  logic [VC_NUM-1:0]               va_grant_i,
  input  logic [VC_NUM-1:0][VC_SIZE-1:0]  va_vc_new_i,
  output logic [VC_NUM-1:0]               sa_req_o,
  input  logic                            sa_grant_i,
  input  logic [VC_SIZE-1:0]              sa_vc_sel_i,
  output flit_t                           flit_o,
  output logic                            flit_valid_o,
  output logic                            error_o
`ifdef IP_PERF_CNT_EN
  ,
  output logic [VC_NUM-1:0][15:0]         perf_flits_o
`endif
);

  logic [VC_NUM-1:0]  w_push;
  logic [VC_NUM-1:0]  w_sa_hit;
  logic [VC_NUM-1:0]  w_fwd_pop;
  logic [VC_NUM-1:0]  w_err;
  flit_t [VC_NUM-1:0] w_fwd_flit;
  logic               w_fwd_any;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign w_push[v]   = valid_flit_i && (data_i.vc_id == VC_SIZE'(v));
    assign w_sa_hit[v] = sa_grant_i && (sa_vc_sel_i == VC_SIZE'(v));

    vc_channel #(
      .BUFFER_SIZE (BUFFER_SIZE),
      .X_CURRENT   (X_CURRENT),
      .Y_CURRENT   (Y_CURRENT)
    ) u_vc (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push[v]),
      .i_flit      (data_i),
      .i_va_grant  (va_grant_i[v]),
      .i_va_vc_new (va_vc_new_i[v]),
      .i_sa_grant  (w_sa_hit[v]),
      .o_va_req    (va_req_o[v]),
      .o_sa_req    (sa_req_o[v]),
      .o_out_port  (out_port_o[v]),
      .o_fwd_pop   (w_fwd_pop[v]),
      .o_fwd_flit  (w_fwd_flit[v]),
      .o_err       (w_err[v])
    );
  end

  // Only the selected VC can pop, so the select also picks the flit
  assign w_fwd_any = |w_fwd_pop;

  // Registered crossbar flit, credit pulse and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_o         <= '0;
      flit_valid_o   <= 1'b0;
      credit_valid_o <= 1'b0;
      credit_vc_o    <= '0;
      error_o        <= 1'b0;
    end else begin
      flit_valid_o   <= w_fwd_any;
      credit_valid_o <= w_fwd_any;
      if (w_fwd_any) begin
        flit_o      <= w_fwd_flit[sa_vc_sel_i];
        credit_vc_o <= sa_vc_sel_i;
      end
      if (|w_err) error_o <= 1'b1;
    end
  end

`ifdef IP_PERF_CNT_EN
  logic [VC_NUM-1:0][15:0] r_perf;

  // Saturating per-VC count of forwarded flits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf <= '0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_fwd_pop[v] && (r_perf[v] != 16'hFFFF)) r_perf[v] <= r_perf[v] + 16'd1;
      end
    end
  end

  assign perf_flits_o = r_perf;
`endif

endmodule

// File: tb/tb_vc_input_port.sv
// Directed bench for vc_input_port: a per-cycle vector table for the basic
// single-flit and four-flit packets, then hand-written sequences for
// interleaving, grant-while-VA, overflow and mid-packet reset.
module tb_vc_input_port;
  import noc_params::*;

  localparam int FW = $bits(flit_t);
  localparam int NV = 13;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flit_t                          data_i;
  logic                           valid_flit_i;
  logic                           credit_valid_o;
  logic [VC_SIZE-1:0]             credit_vc_o;
  port_t [VC_NUM-1:0]             out_port_o;
  logic [VC_NUM-1:0]              va_req_o;
  logic [VC_NUM-1:0]              va_grant_i;
  logic [VC_NUM-1:0][VC_SIZE-1:0] va_vc_new_i;
  logic [VC_NUM-1:0]              sa_req_o;
  logic                           sa_grant_i;
  logic [VC_SIZE-1:0]             sa_vc_sel_i;
  flit_t                          flit_o;
  logic                           flit_valid_o;
  logic                           error_o;
`ifdef IP_PERF_CNT_EN
  logic [VC_NUM-1:0][15:0]        perf_flits_o;
`endif

  vc_input_port #(.BUFFER_SIZE(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_i         (data_i),
    .valid_flit_i   (valid_flit_i),
    .credit_valid_o (credit_valid_o),
    .credit_vc_o    (credit_vc_o),
    .out_port_o     (out_port_o),
    .va_req_o       (va_req_o),
    .va_grant_i     (va_grant_i),
    .va_vc_new_i    (va_vc_new_i),
    .sa_req_o       (sa_req_o),
    .sa_grant_i     (sa_grant_i),
    .sa_vc_sel_i    (sa_vc_sel_i),
    .flit_o         (flit_o),
    .flit_valid_o   (flit_valid_o),
    .error_o        (error_o)
`ifdef IP_PERF_CNT_EN
    ,
    .perf_flits_o   (perf_flits_o)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [FW-1:0] exp_q[$];
  flit_t src0[$];
  flit_t src1[$];

  typedef struct {
    logic        vld;
    flit_t       flit;
    logic [1:0]  va_g;
    logic        sa_g;
    logic        sa_sel;
    logic [1:0]  e_va;
    logic [1:0]  e_sa;
    logic        e_fv;
    logic        e_vcid;
    logic [15:0] e_data;
    logic        e_cv;
    logic        e_cvc;
    port_t       e_p0;
    port_t       e_p1;
  } vec_t;

  vec_t vt [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_flit_i = 1'b0;
    data_i       = '0;
    va_grant_i   = '0;
    sa_grant_i   = 1'b0;
    sa_vc_sel_i  = '0;
  endtask

  task automatic push(input flit_t f);
    valid_flit_i = 1'b1;
    data_i       = f;
    step();
    valid_flit_i = 1'b0;
    data_i       = '0;
  endtask

  function automatic flit_t mk(input flit_label_t l, input logic v, input logic [1:0] x,
                               input logic [1:0] y, input logic [15:0] d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = v;
    f.x_dest     = x;
    f.y_dest     = y;
    f.data       = d;
    return f;
  endfunction

  function automatic flit_t relabel(input flit_t f, input logic v);
    flit_t g;
    g       = f;
    g.vc_id = v;
    return g;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    flit_t fz, f1, ph, pb1, pb2, pt;
    flit_t h0, b0, t0, h1, t1, f;
    int    pops, credits;
    logic  sel;

    fz  = '0;
    f1  = mk(HEADTAIL, 1'b1, 2'd3, 2'd2, 16'h00A1);
    ph  = mk(HEAD,     1'b0, 2'd1, 2'd2, 16'h00B0);
    pb1 = mk(BODY,     1'b0, 2'd0, 2'd0, 16'h00B1);
    pb2 = mk(BODY,     1'b0, 2'd0, 2'd0, 16'h00B2);
    pt  = mk(TAIL,     1'b0, 2'd0, 2'd0, 16'h00B3);

    // HEADTAIL on vc1 to (X+1,Y): EAST, relabelled to downstream vc 0
    vt[0]  = '{1'b1, f1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, LOCAL, LOCAL};
    vt[1]  = '{1'b0, fz, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, LOCAL, EAST};
    vt[2]  = '{1'b0, fz, 2'b10, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, LOCAL, EAST};
    vt[3]  = '{1'b0, fz, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 16'h00A1, 1'b1, 1'b1, LOCAL, EAST};
    vt[4]  = '{1'b0, fz, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, LOCAL, EAST};
    // H,B,B,T on vc0 to WEST with grants held: four back-to-back pops
    vt[5]  = '{1'b1, ph,  2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, LOCAL, EAST};
    vt[6]  = '{1'b1, pb1, 2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, WEST,  EAST};
    vt[7]  = '{1'b1, pb2, 2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, WEST,  EAST};
    vt[8]  = '{1'b1, pt,  2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 16'h00B0, 1'b1, 1'b0, WEST,  EAST};
    vt[9]  = '{1'b0, fz,  2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 16'h00B1, 1'b1, 1'b0, WEST,  EAST};
    vt[10] = '{1'b0, fz,  2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 16'h00B2, 1'b1, 1'b0, WEST,  EAST};
    vt[11] = '{1'b0, fz,  2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 16'h00B3, 1'b1, 1'b0, WEST,  EAST};
    vt[12] = '{1'b0, fz,  2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, WEST,  EAST};

    // Reset: downstream VC map vc0->1, vc1->0 for the whole run
    rst = 1'b1;
    idle_inputs();
    va_vc_new_i = 2'b01;
    step();
    step();
    check("rst_flit_valid",  32'(flit_valid_o),   32'd0);
    check("rst_credit",      32'(credit_valid_o), 32'd0);
    check("rst_va_req",      32'(va_req_o),       32'd0);
    check("rst_sa_req",      32'(sa_req_o),       32'd0);
    check("rst_error",       32'(error_o),        32'd0);
    check("rst_flit_o",      32'(flit_o),         32'd0);
    check("rst_port0",       32'(out_port_o[0]),  32'(LOCAL));
    check("rst_port1",       32'(out_port_o[1]),  32'(LOCAL));
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < NV; i++) begin
      valid_flit_i = vt[i].vld;
      data_i       = vt[i].flit;
      va_grant_i   = vt[i].va_g;
      sa_grant_i   = vt[i].sa_g;
      sa_vc_sel_i  = vt[i].sa_sel;
      step();
      check($sformatf("v%0d_va_req", i),     32'(va_req_o),       32'(vt[i].e_va));
      check($sformatf("v%0d_sa_req", i),     32'(sa_req_o),       32'(vt[i].e_sa));
      check($sformatf("v%0d_flit_valid", i), 32'(flit_valid_o),   32'(vt[i].e_fv));
      check($sformatf("v%0d_credit", i),     32'(credit_valid_o), 32'(vt[i].e_cv));
      check($sformatf("v%0d_port0", i),      32'(out_port_o[0]),  32'(vt[i].e_p0));
      check($sformatf("v%0d_port1", i),      32'(out_port_o[1]),  32'(vt[i].e_p1));
      check($sformatf("v%0d_error", i),      32'(error_o),        32'd0);
      if (vt[i].e_fv) begin
        check($sformatf("v%0d_vc_id", i), 32'(flit_o.vc_id), 32'(vt[i].e_vcid));
        check($sformatf("v%0d_data", i),  32'(flit_o.data),  32'(vt[i].e_data));
      end
      if (vt[i].e_cv) check($sformatf("v%0d_credit_vc", i), 32'(credit_vc_o), 32'(vt[i].e_cvc));
    end
    idle_inputs();
    check("table_vc0_idle", 32'(dut.g_vc[0].u_vc.r_state), 32'(IDLE));
    check("table_vc1_idle", 32'(dut.g_vc[1].u_vc.r_state), 32'(IDLE));

    // Interleaved packets; vc0 -> NORTH, vc1 -> SOUTH
    h0 = mk(HEAD, 1'b0, 2'd2, 2'd0, 16'h0400);
    b0 = mk(BODY, 1'b0, 2'd0, 2'd0, 16'h0401);
    t0 = mk(TAIL, 1'b0, 2'd0, 2'd0, 16'h0402);
    h1 = mk(HEAD, 1'b1, 2'd2, 2'd3, 16'h0410);
    t1 = mk(TAIL, 1'b1, 2'd0, 2'd0, 16'h0411);
    src0 = '{h0, b0, t0};
    src1 = '{h1, t1};
    push(h0);
    push(h1);
    push(b0);
    push(t1);
    push(t0);
    step();
    check("il_va_req_both", 32'(va_req_o),      32'b11);
    check("il_port0_north", 32'(out_port_o[0]), 32'(NORTH));
    check("il_port1_south", 32'(out_port_o[1]), 32'(SOUTH));

    // Switch grant to vc1 while it is still in VA must be ignored
    sa_grant_i  = 1'b1;
    sa_vc_sel_i = 1'b1;
    step();
    sa_grant_i  = 1'b0;
    check("va_sa_no_pop",      32'(flit_valid_o),               32'd0);
    check("va_sa_no_credit",   32'(credit_valid_o),             32'd0);
    check("va_sa_still_req",   32'(va_req_o),                   32'b11);
    check("va_sa_state_kept",  32'(dut.g_vc[1].u_vc.r_state),   32'(VA));

    va_grant_i = 2'b11;
    step();
    va_grant_i = 2'b00;
    check("il_active_va_req", 32'(va_req_o), 32'b00);
    check("il_active_sa_req", 32'(sa_req_o), 32'b11);

    for (int i = 0; i < 5; i++) begin
      sel         = i[0];
      sa_grant_i  = 1'b1;
      sa_vc_sel_i = sel;
      f = sel ? src1.pop_front() : src0.pop_front();
      exp_q.push_back(relabel(f, ~sel));
      step();
      check($sformatf("il%0d_valid", i),     32'(flit_valid_o), 32'd1);
      check($sformatf("il%0d_flit", i),      32'(flit_o),       32'(exp_q.pop_front()));
      check($sformatf("il%0d_credit_vc", i), 32'(credit_vc_o),  32'(sel));
    end
    idle_inputs();
    check("il_vc0_idle",  32'(dut.g_vc[0].u_vc.r_state), 32'(IDLE));
    check("il_vc1_idle",  32'(dut.g_vc[1].u_vc.r_state), 32'(IDLE));
    check("il_sa_req_end", 32'(sa_req_o), 32'b00);

    // Overflow: nine pushes into an 8-deep vc0 with no grants
    for (int i = 0; i < 9; i++) begin
      f = mk((i == 0) ? HEAD : ((i == 7) ? TAIL : BODY), 1'b0, 2'd3, 2'd3, 16'(16'h0300 + i));
      if (i < 8) exp_q.push_back(relabel(f, 1'b1));
      push(f);
      if (i == 7) check("ovf_err_before", 32'(error_o), 32'd0);
    end
    check("ovf_err_after", 32'(error_o), 32'd1);
    va_grant_i = 2'b01;
    step();
    va_grant_i  = 2'b00;
    sa_grant_i  = 1'b1;
    sa_vc_sel_i = 1'b0;
    pops = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (flit_valid_o) begin
        pops++;
        if (exp_q.size() > 0) check($sformatf("ovf_flit%0d", pops), 32'(flit_o), 32'(exp_q.pop_front()));
      end
    end
    idle_inputs();
    check("ovf_pop_count", 32'(pops),         32'd8);
    check("ovf_q_drained", 32'(exp_q.size()), 32'd0);
    check("ovf_err_sticky", 32'(error_o),     32'd1);

    // Reset with three flits buffered on an ACTIVE vc1
    push(mk(HEAD, 1'b1, 2'd0, 2'd2, 16'h0600));
    push(mk(BODY, 1'b1, 2'd0, 2'd0, 16'h0601));
    push(mk(BODY, 1'b1, 2'd0, 2'd0, 16'h0602));
    va_grant_i = 2'b10;
    step();
    va_grant_i = 2'b00;
    check("mr_sa_req_pre", 32'(sa_req_o),      32'b10);
    check("mr_port1_pre",  32'(out_port_o[1]), 32'(WEST));
    rst         = 1'b1;
    sa_grant_i  = 1'b1;
    sa_vc_sel_i = 1'b1;
    step();
    rst = 1'b0;
    check("mr_flit_valid", 32'(flit_valid_o),   32'd0);
    check("mr_credit",     32'(credit_valid_o), 32'd0);
    check("mr_va_req",     32'(va_req_o),       32'd0);
    check("mr_sa_req",     32'(sa_req_o),       32'd0);
    check("mr_error",      32'(error_o),        32'd0);
    check("mr_flit_o",     32'(flit_o),         32'd0);
    check("mr_port1",      32'(out_port_o[1]),  32'(LOCAL));
    check("mr_vc1_idle",   32'(dut.g_vc[1].u_vc.r_state), 32'(IDLE));
    va_grant_i = 2'b11;
    credits = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (credit_valid_o) credits++;
    end
    idle_inputs();
    check("mr_no_credits", 32'(credits),  32'd0);
    check("mr_va_req_end", 32'(va_req_o), 32'd0);
    check("mr_sa_req_end", 32'(sa_req_o), 32'd0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_input_port.md
Name: vc_input_port

Overview:
Next-generation router input port with VC_NUM independent virtual channels. Each VC has its own FIFO and state machine (IDLE/VA/ACTIVE). Route computation runs per packet on the head flit at the FIFO front. The port requests VC and switch allocation, relabels forwarded flits with the granted downstream VC, and returns one credit upstream per popped flit. It sits between the upstream link and the VC allocator, switch allocator and crossbar.

Parameters:
VC_NUM, 2, number of virtual channels (power of two, ≥2); VC_SIZE = $clog2(VC_NUM)
BUFFER_SIZE, 8, flits per VC FIFO (power of two, ≥2)
X_CURRENT, MESH_SIZE_X/2, router x coordinate, passed to rc_unit
Y_CURRENT, MESH_SIZE_Y/2, router y coordinate, passed to rc_unit

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
data_i  in  flit_t  incoming flit; vc_id selects the target VC
valid_flit_i  in  1  data_i valid this cycle
credit_valid_o  out  1  one credit returned upstream
credit_vc_o  out  VC_SIZE  VC that the credit belongs to
out_port_o  out  VC_NUM x port_t  latched route per VC
va_req_o  out  VC_NUM  VC allocation request per VC
va_grant_i  in  VC_NUM  VC allocation grant per VC
va_vc_new_i  in  VC_NUM x VC_SIZE  granted downstream VC per VC
sa_req_o  out  VC_NUM  switch allocation request per VC
sa_grant_i  in  1  switch grant valid
sa_vc_sel_i  in  VC_SIZE  VC to pop on grant
flit_o  out  flit_t  flit to crossbar, vc_id rewritten to downstream VC
flit_valid_o  out  1  flit_o valid
error_o  out  1  sticky protocol or overflow error

Behaviour:
- Reset: all FIFOs empty, all VCs IDLE, out_port_o=LOCAL, downstream VC=0. va_req_o, sa_req_o, flit_valid_o, credit_valid_o, error_o are all 0; flit_o=0.
- Write: when valid_flit_i=1, data_i is pushed into FIFO[data_i.vc_id].
  - Push into a full FIFO: the flit is dropped and error_o is set.
  - Simultaneous push and pop on the same VC is legal; occupancy is unchanged, including when the FIFO is full.
- Per-VC FSM:
  - IDLE: if the FIFO is non-empty and the front flit is HEAD or HEADTAIL, latch out_port from rc_unit on the front flit's x_dest/y_dest, then go to VA. If the front flit is BODY or TAIL, pop and discard it, set error_o, and emit no credit.
  - VA: va_req_o[vc]=1. On va_grant_i[vc], latch va_vc_new_i[vc] and go to ACTIVE in the next cycle. va_req_o drops in the same cycle as the transition.
  - ACTIVE: sa_req_o[vc]=1 whenever the FIFO is non-empty. On sa_grant_i with sa_vc_sel_i=vc, pop the front flit. If the popped flit is TAIL or HEADTAIL, go to IDLE.
- Minimum latency from head flit at the front of an empty IDLE VC to flit_valid_o is 3 cycles, given immediate grants.
- Grant handling:
  - A grant to a VC that is not requesting is ignored: no pop, no state change.
  - va_grant_i while in IDLE or ACTIVE is ignored.
- Output: registered. Flit_o equals the popped flit with vc_id replaced by the latched downstream VC. flit_valid_o, credit_valid_o and credit_vc_o assert in the cycle after the grant, for exactly 1 cycle per pop.
- Back-to-back packets in one VC: after the tail pops, the VC returns to IDLE. The next head is routed from the FIFO front in the following cycle.
- rst asserted mid-packet: all state clears on the next edge, FIFO contents are discarded, and no credits are emitted for discarded flits.
- Pointers: width $clog2(BUFFER_SIZE)+1; the extra MSB distinguishes full from empty. Wrap-around is natural.

Optional Feature:
IP_PERF_CNT_EN
- Defined: adds output perf_flits_o, VC_NUM x 16 bits. Each counter increments by 1 per popped and forwarded flit of its VC, saturates at 16'hFFFF, and clears on rst.
- Undefined: the port and its counters are absent; all other behaviour is identical.

Decomposition:
- noc_params package: flit_t, flit_label_t (HEAD/BODY/TAIL/HEADTAIL), port_t, VC_NUM, VC_SIZE, MESH_SIZE_X/Y, DEST_ADDR_SIZE_X/Y, and new enum vc_state_t {IDLE, VA, ACTIVE}.
- Sub-module vc_channel: one FIFO plus FSM plus latched out_port and downstream VC, instantiated VC_NUM times via generate.
- rc_unit: reused, one instance per VC on that VC's FIFO front.

Test Plan:
- Reset, then a HEADTAIL on vc 1 to dest (X_CURRENT+1, Y_CURRENT): out_port_o[1]=EAST, va_req_o[1]=1. va_grant_i[1] with vc_new=0, then sa grant with vc_sel=1: flit_o.vc_id=0, flit_valid_o=1, credit_vc_o=1, and VC 1 returns to IDLE.
- A 4-flit packet (H,B,B,T) on vc 0 with continuous grants: 4 consecutive flit_valid_o pulses, 4 credits on vc 0, and the FSM ends in IDLE.
- Push 9 flits into vc 0 with BUFFER_SIZE=8 and no grants: the 9th is dropped, error_o=1, and later pops return exactly 8 flits.
- Interleaved packets on vc 0 and vc 1, alternating sa_vc_sel_i: per-VC flit order is preserved and downstream vc_ids are correct.
- sa_grant_i with vc_sel=1 while VC 1 is in VA: no pop, flit_valid_o=0, and the state is unchanged.
- Assert rst mid-packet with 3 flits buffered: all outputs return to reset values and no credits are emitted.
